// File: rtl/sid_waveform_mv_if.sv
// Beat stream from sid_waveform_mv to the waveform mixer / DAC.
// Handshake: out_valid qualifies one beat per cycle; there is no ready, so the consumer must take every beat.
interface sid_waveform_mv_if #(
    parameter int VOICES    = 3,
    parameter int OUT_WIDTH = 12
);
    localparam int VW = $clog2(VOICES);

    logic                 out_valid;
    logic [VW-1:0]        out_voice;
    logic [3:0]           out_selector;
    logic [OUT_WIDTH-1:0] out_saw_tri;
    logic                 out_pulse;
    logic [7:0]           out_noise;

    modport master (
        output out_valid, out_voice, out_selector, out_saw_tri, out_pulse, out_noise
    );
    modport slave (
        input out_valid, out_voice, out_selector, out_saw_tri, out_pulse, out_noise
    );
endinterface

// File: rtl/sid_waveform_mv.sv
// Time-multiplexed multi-voice SID waveform generator: per tick, one ADD pass and one SYNC/output pass.
// Optional ring modulation is enabled by defining SID_WFMV_RINGMOD_EN.
module sid_waveform_mv #(
    parameter int VOICES     = 3,
    parameter int ACC_WIDTH  = 24,
    parameter int FREQ_WIDTH = 16,
    parameter int OUT_WIDTH  = 12
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         tick,
    input  logic [VOICES*FREQ_WIDTH-1:0] freq,
    input  logic [VOICES*OUT_WIDTH-1:0]  pw,
    input  logic [VOICES*7-1:0]          ctrl,
    sid_waveform_mv_if.master            wf,
    output logic                         busy,
    output logic                         overrun,
    output logic [1:0]                   dbg_state
);
    localparam int VW  = $clog2(VOICES);
    localparam int LW  = 23;
    localparam int NB  = ACC_WIDTH - 5;
    localparam int PW2 = (ACC_WIDTH + 1) / 2;
    localparam logic [VW-1:0]        LAST      = VW'(VOICES - 1);
    localparam logic [2*PW2-1:0]     ACC_PAT_W = {PW2{2'b01}};
    localparam logic [ACC_WIDTH-1:0] ACC_INIT  = ACC_PAT_W[ACC_WIDTH-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [VW-1:0] idx, idx_nx;

    logic [ACC_WIDTH-1:0] acc  [VOICES];
    logic [LW-1:0]        lfsr [VOICES];
    logic [VOICES-1:0]    up;

    logic [FREQ_WIDTH-1:0] freq_a [VOICES];
    logic [OUT_WIDTH-1:0]  pw_a   [VOICES];
    logic [3:0]            sel_a  [VOICES];
    logic [VOICES-1:0]     test_v, sync_v, so_v;

    logic                 valid_q;
    logic [VW-1:0]        voice_q;
    logic [3:0]           sel_q;
    logic [OUT_WIDTH-1:0] saw_tri_q;
    logic                 pulse_q;
    logic [7:0]           noise_q;

    logic [VW-1:0]        src_idx;
    logic [ACC_WIDTH-1:0] cur_acc, sum;
    logic [LW-1:0]        cur_lfsr, lfsr_nx;
    logic                 noise_clk, rst_i, msb, saw, tri_xor, pulse;
    logic [OUT_WIDTH-1:0] top, saw_tri;
    logic [7:0]           noise;

`ifdef SID_WFMV_RINGMOD_EN
    logic [VOICES-1:0] ring_v;
    logic [VOICES-1:0] msb_add;
`endif

    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            freq_a[v] = freq[v*FREQ_WIDTH +: FREQ_WIDTH];
            pw_a[v]   = pw[v*OUT_WIDTH +: OUT_WIDTH];
            sel_a[v]  = ctrl[v*7+3 +: 4];
            test_v[v] = ctrl[v*7+2];
            sync_v[v] = ctrl[v*7];
`ifdef SID_WFMV_RINGMOD_EN
            ring_v[v] = ctrl[v*7+1];
`endif
        end
    end

    // so_v[x]: voice x is itself being reset this sweep, which masks it as a sync source.
    always_comb begin
        for (int x = 0; x < VOICES; x++) begin
            so_v[x] = test_v[x] | (sync_v[x] & up[(x + VOICES - 1) % VOICES]);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nx = ST_ADD;
                    idx_nx   = '0;
                end
            end
            ST_ADD: begin
                if (idx == LAST) begin
                    state_nx = ST_SYNC;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            ST_SYNC: begin
                if (idx == LAST) begin
                    state_nx = ST_IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    assign dbg_state = state;

    // Shared per-voice datapath: in ADD cur_acc is pre-add, in SYNC it is the post-add value.
    always_comb begin
        src_idx   = (idx == '0) ? LAST : idx - 1'b1;
        cur_acc   = acc[idx];
        sum       = cur_acc + ACC_WIDTH'(freq_a[idx]);
        noise_clk = ~cur_acc[NB] & sum[NB];
        cur_lfsr  = lfsr[idx];
        if (test_v[idx]) begin
            lfsr_nx = '1;
        end else if (noise_clk) begin
            lfsr_nx = {cur_lfsr[21:0], cur_lfsr[22] ^ cur_lfsr[17]};
        end else begin
            lfsr_nx = cur_lfsr;
        end
        rst_i = test_v[idx] | (sync_v[idx] & up[src_idx] & ~so_v[src_idx]);
        top   = rst_i ? '0 : cur_acc[ACC_WIDTH-1 -: OUT_WIDTH];
        msb   = top[OUT_WIDTH-1];
        saw   = sel_a[idx][1];
`ifdef SID_WFMV_RINGMOD_EN
        tri_xor = ~saw & ((ring_v[idx] & ~msb_add[src_idx]) ^ msb);
`else
        tri_xor = ~saw & msb;
`endif
        saw_tri = {msb, top[OUT_WIDTH-2:0] ^ {(OUT_WIDTH-1){tri_xor}}};
        pulse   = (top >= pw_a[idx]) | test_v[idx];
        noise   = {cur_lfsr[20], cur_lfsr[18], cur_lfsr[14], cur_lfsr[11],
                   cur_lfsr[9],  cur_lfsr[5],  cur_lfsr[2],  cur_lfsr[0]};
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int v = 0; v < VOICES; v++) begin
                acc[v]  <= ACC_INIT;
                lfsr[v] <= '1;
            end
            up        <= '0;
`ifdef SID_WFMV_RINGMOD_EN
            msb_add   <= '0;
`endif
            valid_q   <= 1'b0;
            voice_q   <= '0;
            sel_q     <= '0;
            saw_tri_q <= '0;
            pulse_q   <= 1'b0;
            noise_q   <= '0;
            overrun   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (tick && busy) begin
                overrun <= 1'b1;
            end
            if (state == ST_ADD) begin
                acc[idx]  <= sum;
                up[idx]   <= ~cur_acc[ACC_WIDTH-1] & sum[ACC_WIDTH-1];
                lfsr[idx] <= lfsr_nx;
`ifdef SID_WFMV_RINGMOD_EN
                msb_add[idx] <= sum[ACC_WIDTH-1];
`endif
            end else if (state == ST_SYNC) begin
                if (rst_i) begin
                    acc[idx] <= '0;
                end
                valid_q   <= 1'b1;
                voice_q   <= idx;
                sel_q     <= sel_a[idx];
                saw_tri_q <= saw_tri;
                pulse_q   <= pulse;
                noise_q   <= noise;
            end
        end
    end

    assign wf.out_valid    = valid_q;
    assign wf.out_voice    = voice_q;
    assign wf.out_selector = sel_q;
    assign wf.out_saw_tri  = saw_tri_q;
    assign wf.out_pulse    = pulse_q;
    assign wf.out_noise    = noise_q;
endmodule

// File: tb/tb_sid_waveform_mv.sv
// Directed + randomized bench for sid_waveform_mv against a whole-sweep behavioural model.
module tb_sid_waveform_mv;
    localparam int V  = 3;
    localparam int AW = 24;
    localparam int FW = 24;
    localparam int OW = 12;
    localparam logic [31:0] ACC_MASK  = 32'h00FF_FFFF;
    localparam logic [31:0] LFSR_ONES = 32'h007F_FFFF;

    logic          clk;
    logic          res;
    logic          tick;
    logic [V*FW-1:0] freq;
    logic [V*OW-1:0] pw;
    logic [V*7-1:0]  ctrl;
    logic          busy;
    logic          overrun;
    logic [1:0]    dbg_state;

    sid_waveform_mv_if #(.VOICES(V), .OUT_WIDTH(OW)) wf ();

    sid_waveform_mv #(
        .VOICES(V), .ACC_WIDTH(AW), .FREQ_WIDTH(FW), .OUT_WIDTH(OW)
    ) dut (
        .clk(clk), .res(res), .tick(tick), .freq(freq), .pw(pw), .ctrl(ctrl),
        .wf(wf), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    logic [31:0] f_v [V];
    logic [31:0] p_v [V];
    logic [6:0]  c_v [V];
    logic [31:0] m_acc [V];
    logic [31:0] m_lfsr [V];
    logic        m_ovr;
    logic [26:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_voice(input int v, input logic [31:0] f, input logic [31:0] p, input logic [6:0] c);
        f_v[v] = f & ACC_MASK;
        p_v[v] = p & 32'h0000_0FFF;
        c_v[v] = c;
        freq[v*FW +: FW] = f[FW-1:0];
        pw[v*OW +: OW]   = p[OW-1:0];
        ctrl[v*7 +: 7]   = c;
    endtask

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            m_acc[v]  = 32'h0055_5555;
            m_lfsr[v] = LFSR_ONES;
        end
        m_ovr = 1'b0;
        exp_q.delete();
    endtask

    // Whole-sweep reference: all additions first, then all sync decisions and beats.
    task automatic model_sweep();
        logic        up [V];
        logic        mp [V];
        logic        so [V];
        logic [31:0] old, s, top, st;
        logic        nclk, rst, msb, trix, pul, nb;
        logic [22:0] l;
        logic [7:0]  nz;
        int          src;
        for (int v = 0; v < V; v++) begin
            old   = m_acc[v];
            s     = (old + f_v[v]) & ACC_MASK;
            up[v] = !old[AW-1] && s[AW-1];
            nclk  = !old[AW-5] && s[AW-5];
            mp[v] = s[AW-1];
            m_acc[v] = s;
            if (c_v[v][2]) begin
                m_lfsr[v] = LFSR_ONES;
            end else if (nclk) begin
                nb = m_lfsr[v][22] ^ m_lfsr[v][17];
                m_lfsr[v] = ((m_lfsr[v] << 1) | {31'd0, nb}) & LFSR_ONES;
            end
        end
        for (int x = 0; x < V; x++) begin
            so[x] = c_v[x][2] || (c_v[x][0] && up[(x + V - 1) % V]);
        end
        for (int i = 0; i < V; i++) begin
            src = (i + V - 1) % V;
            rst = c_v[i][2] || (c_v[i][0] && up[src] && !so[src]);
            if (rst) m_acc[i] = 32'd0;
            top = m_acc[i] >> (AW - OW);
            msb = top[OW-1];
`ifdef SID_WFMV_RINGMOD_EN
            trix = !c_v[i][4] && ((c_v[i][1] && !mp[src]) ^ msb);
`else
            trix = !c_v[i][4] && msb;
`endif
            st  = trix ? (top ^ 32'h7FF) : top;
            pul = (top >= p_v[i]) || c_v[i][2];
            l   = m_lfsr[i][22:0];
            nz  = {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0]};
            exp_q.push_back({2'(i), c_v[i][6:3], st[11:0], pul, nz});
        end
    endtask

    // Tick at the current negedge, then check every cycle of the sweep; inj>0 re-ticks at that cycle.
    task automatic run_sweep(input int inj);
        logic [26:0] b;
        model_sweep();
        tick = 1'b1;
        for (int n = 1; n <= 2*V+1; n++) begin
            @(negedge clk);
            tick = (inj != 0 && n == inj);
            if (inj != 0 && n == inj + 1) m_ovr = 1'b1;
            check("busy", {31'd0, busy}, {31'd0, n <= 2*V});
            check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            check("out_valid", {31'd0, wf.out_valid}, {31'd0, n >= V+2});
            if (n >= V+2) begin
                b = exp_q.pop_front();
                check("out_voice", {30'd0, wf.out_voice}, {30'd0, b[26:25]});
                check("out_selector", {28'd0, wf.out_selector}, {28'd0, b[24:21]});
                check("out_saw_tri", {20'd0, wf.out_saw_tri}, {20'd0, b[20:9]});
                check("out_pulse", {31'd0, wf.out_pulse}, {31'd0, b[8]});
                check("out_noise", {24'd0, wf.out_noise}, {24'd0, b[7:0]});
            end
        end
    endtask

    task automatic pulse_reset();
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        model_reset();
    endtask

    initial begin
        res  = 1'b1;
        tick = 1'b0;
        freq = '0;
        pw   = '0;
        ctrl = '0;
        for (int v = 0; v < V; v++) set_voice(v, 32'd0, 32'd0, 7'h10);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_valid", {31'd0, wf.out_valid}, 32'd0);
        check("rst_voice", {30'd0, wf.out_voice}, 32'd0);
        check("rst_selector", {28'd0, wf.out_selector}, 32'd0);
        check("rst_saw_tri", {20'd0, wf.out_saw_tri}, 32'd0);
        check("rst_pulse", {31'd0, wf.out_pulse}, 32'd0);
        check("rst_noise", {24'd0, wf.out_noise}, 32'd0);
        res = 1'b0;
        @(negedge clk);

        // freq=0 saw on all voices: each beat shows 0x555
        run_sweep(0);

        // Voice0 stepping saw, then faster to force a wrap
        set_voice(0, 32'h1000, 32'h0, 7'h10);
        for (int k = 0; k < 16; k++) run_sweep(0);
        set_voice(0, 32'h20_0000, 32'h0, 7'h10);
        for (int k = 0; k < 10; k++) run_sweep(0);

        // Voice1 hard-synced to voice0 MSB toggling every sweep
        pulse_reset();
        set_voice(0, 32'h80_0000, 32'h0, 7'h10);
        set_voice(1, 32'h10, 32'h0, 7'h11);
        set_voice(2, 32'h100, 32'h0, 7'h10);
        for (int k = 0; k < 6; k++) run_sweep(0);

        // Every voice synced and rising together: nobody resets
        pulse_reset();
        for (int v = 0; v < V; v++) set_voice(v, 32'h80_0000, 32'h0, 7'h11);
        for (int k = 0; k < 4; k++) run_sweep(0);

        // Test bit on voice0
        set_voice(0, 32'h1234, 32'hFFF, 7'h04);
        set_voice(1, 32'h10, 32'h800, 7'h20);
        set_voice(2, 32'h10, 32'h000, 7'h40);
        for (int k = 0; k < 2; k++) run_sweep(0);

        // Triangle with ring on voice1, source MSB alternating
        set_voice(0, 32'h80_0000, 32'h0, 7'h10);
        set_voice(1, 32'h1_0000, 32'h400, 7'h0A);
        set_voice(2, 32'h8_0000, 32'h200, 7'h08);
        for (int k = 0; k < 4; k++) run_sweep(0);

        // Randomized voices
        for (int k = 0; k < 24; k++) begin
            for (int v = 0; v < V; v++) begin
                logic [6:0] c;
                c = 7'($urandom_range(0, 127)) & 7'h7B;
                if ($urandom_range(0, 7) == 0) c = c | 7'h04;
                set_voice(v, $urandom, 32'($urandom_range(0, 4095)), c);
            end
            run_sweep(0);
        end

        // Tick while busy: overrun sticks, sweep still completes
        run_sweep(3);
        run_sweep(0);

        // Reset during ADD aborts the sweep immediately
        for (int v = 0; v < V; v++) set_voice(v, 32'h0, 32'h0, 7'h10);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        res = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, wf.out_valid}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        res = 1'b0;
        model_reset();
        for (int k = 0; k < 2*V+2; k++) begin
            @(negedge clk);
            check("post_rst_valid", {31'd0, wf.out_valid}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        run_sweep(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sid_waveform_mv.md
# sid_waveform_mv

Time-multiplexed, parametrised multi-voice SID waveform generator. It holds one phase accumulator and one noise LFSR per voice in registers. A sweep is started by `tick` and processes all voices one per clock in two passes: accumulate, then sync and output. Per-voice waveform components are streamed to the downstream waveform mixer / DAC. Sync and ring modulation generalise to a circular chain of VOICES voices.

## Interface
- VOICES, 3: voice count, ≥2; voice v's sync/ring source is voice (v-1) mod VOICES.
- ACC_WIDTH, 24: accumulator width, ≥16.
- FREQ_WIDTH, 16: frequency word width, ≤ACC_WIDTH, zero-extended.
- OUT_WIDTH, 12: saw/tri and pulse-width width, ≤ACC_WIDTH-1.
- clk  in  1  system clock.
- res  in  1  reset; one clock, asynchronous, active-high.
- tick  in  1  start sweep (one SID cycle).
- freq  in  VOICES*FREQ_WIDTH  per-voice frequency; voice v at slice v.
- pw  in  VOICES*OUT_WIDTH  per-voice pulse width.
- ctrl  in  VOICES*7  per voice: [6]noise [5]pulse [4]saw [3]tri [2]test [1]ring [0]sync.
- out_valid  out  1  output beat strobe.
- out_voice  out  $clog2(VOICES)  voice of current beat.
- out_selector  out  4  {noise,pulse,saw,tri}.
- out_saw_tri  out  OUT_WIDTH  saw/triangle value.
- out_pulse  out  1  pulse bit.
- out_noise  out  8  LFSR bits {20,18,14,11,9,5,2,0}.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky: tick arrived while busy.

## Operation
- FSM: IDLE -> ADD (VOICES cycles, index 0..V-1) -> SYNC (VOICES cycles) -> IDLE. `tick` in IDLE is accepted. `tick` in ADD/SYNC is ignored and sets overrun.
- ADD, voice i: sum = acc[i] + freq[i] mod 2^ACC_WIDTH. Store sum. up[i] = ~old_msb & sum_msb. Noise clock: bit ACC_WIDTH-5 of acc rises 0->1.
- Noise clocked: lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]} (23-bit). test=1: lfsr <= all ones.
- SYNC, voice i with src s: so[x] = test[x] | (sync[x] & up[src(x)]). rst_i = test[i] | (sync[i] & up[s] & ~so[s]).
  - If every voice has sync=1 and every up=1, no voice resets.
- rst_i: acc[i] <= 0. All further outputs for voice i use the post-sync value A.
- msb = A[ACC_WIDTH-1]; top = A[ACC_WIDTH-1 -: OUT_WIDTH].
- tri_xor = ~saw & ((ring & ~msb(src A)) ^ msb). Source msb is post-ADD, pre-SYNC.
- out_saw_tri = {msb, top[OUT_WIDTH-2:0] ^ {tri_xor}}.
- out_pulse = (top >= pw[i]) | test.
- out_noise is taken after this sweep's noise update.
- Reset (async): acc = alternating 01 pattern (24-bit: 0x555555). lfsr = all ones. FSM IDLE. up = 0. All outputs 0, overrun 0.
- Reset mid-sweep aborts the sweep; no partial beats after release.
- Freq/pw/ctrl are sampled in the cycle of use. They must be stable from tick until busy falls; otherwise the result is undefined per voice.

## Timing
- tick accepted at cycle T. ADD of voice i at T+1+i. SYNC of voice i at T+V+1+i.
- Registered outputs: out_valid=1, out_voice=i at T+V+2+i. Otherwise out_valid=0 and other outputs hold their last value.
- busy=1 for T+1..T+2V. The next tick is accepted from T+2V+1 (busy=0 in that cycle).
- Throughput: one sweep per 2V+1 clocks minimum. overrun is set the cycle after the offending tick.

## Configuration
- SID_WFMV_RINGMOD_EN defined: ring modulation as above.
- Undefined: ring bit ignored, tri_xor = ~saw & msb, no source-MSB path.
- Sync is unaffected in both cases.

## Test plan
- Reset, then tick, freq=0, ctrl=saw for all voices -> three beats at T+5..T+7, out_voice 0,1,2, out_saw_tri=0x555, busy low at T+7.
- Voice0 freq=0x1000, saw, 16 ticks -> beat k has saw_tri=0x555+k. Wraps 0xFFF->0x000 correctly.
- Voice0 freq=0x800000 (MSB toggles each sweep), voice1 sync=1 freq=0x10 -> voice1 saw_tri=0x000 on sweeps where voice0 MSB rises; voice2 unaffected.
- All voices sync=1, freq=0x800000, all MSBs rising same sweep -> no voice reset; accumulators = 0x800000 pattern continues.
- Voice0 test=1, pw=0xFFF -> out_pulse=1, out_saw_tri=0, out_noise=0xFF. Triangle+ring with source MSB=1 vs 0 -> saw_tri lower bits inverted per rule; with macro undefined, no inversion change.
- tick while busy -> overrun=1, sweep completes with 3 beats. res asserted mid-ADD -> busy=0, out_valid=0 immediately, acc 0x555555.
